// File: rtl/mcyc_ctl_pkg.sv
// Shared constants for the multicycle controller and the ALU control decoder.
// Holds state codes, opcodes, ALUOp codes, the control-word layout and a legality helper.
package mcyc_ctl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op, input logic addi_en);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_J, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
            OP_ADDI:                          ok = addi_en;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mcyc_ctl_outdec.sv
// Moore output decode: maps a state code to the packed control word.
// Ports: state_i (4b state code), ctrl_o (16b control word, ctrl_t layout).
module mcyc_ctl_outdec
    import mcyc_ctl_pkg::*;
(
    input  logic [3:0]  state_i,
    output logic [15:0] ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_i)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_BOFF;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_OUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/mcyc_ctl.sv
// Multicycle MIPS-style main controller: Moore FSM with state register and next-state logic.
// Ports: clk, reset (sync, active high), Op (6b), datapath strobes/selects, state (debug), illegal_op.
module mcyc_ctl
    import mcyc_ctl_pkg::*;
#(
    parameter int ENABLE_ADDI = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic ADDI_EN = (ENABLE_ADDI != 0);

    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [15:0] dec_word;
    ctrl_t       cw;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW)
                    state_d = S_MEMADR;
                else if (Op == OP_R)
                    state_d = S_EXEC;
                else if (Op == OP_BEQ)
                    state_d = S_BRANCH;
                else if (Op == OP_J)
                    state_d = S_JUMP;
                else if (Op == OP_ADDI && ADDI_EN)
                    state_d = S_ADDIEX;
                else
                    state_d = S_FETCH;
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_EXEC:   state_d = S_RWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    mcyc_ctl_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (dec_word)
    );

    // Reset masks the strobes combinationally so an aborted
    // instruction cannot write anything in the reset cycle.
    assign cw = reset ? '0 : ctrl_t'(dec_word);

    assign PCWrite     = cw.pc_write;
    assign PCWriteCond = cw.pc_write_cond;
    assign IorD        = cw.iord;
    assign MemRead     = cw.mem_read;
    assign MemWrite    = cw.mem_write;
    assign MemtoReg    = cw.mem_to_reg;
    assign IRWrite     = cw.ir_write;
    assign ALUSrcA     = cw.alu_src_a;
    assign RegWrite    = cw.reg_write;
    assign RegDst      = cw.reg_dst;
    assign PCSource    = cw.pc_source;
    assign ALUSrcB     = cw.alu_src_b;
    assign ALUOp       = cw.alu_op;

    assign state      = reset ? S_FETCH : state_q;
    assign illegal_op = ~reset & (state_q == S_DECODE)
                      & ~op_legal(Op, ADDI_EN);

endmodule
